// File: rtl/prefetch_pkg.sv
// Shared types and default sizes for the instruction prefetch buffer.
//   S_IDLE/S_WAIT/S_DISCARD : memory-side fetch FSM states
//   fetch_entry_t           : one FIFO entry {addr, instr} at the default widths
package prefetch_pkg;

  localparam int unsigned OPERAND_WIDTH_DEF     = 11;
  localparam int unsigned INSTRUCTION_WIDTH_DEF = 16;
  localparam int unsigned DEPTH_DEF             = 4;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } fsm_state_t;

  typedef struct packed {
    logic [OPERAND_WIDTH_DEF-1:0]     addr;
    logic [INSTRUCTION_WIDTH_DEF-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/prefetch_fifo.sv
// Prefetch FIFO: DEPTH entries with read/write pointers and an occupancy count.
// Ports:
//   i_clk, i_rst_n        : clock, async active-low reset
//   i_push, i_data        : write an entry
//   i_pop                 : drop the head entry (only when non-empty)
//   i_flush               : empty the FIFO; overrides a push on the same edge
//   o_head                : current head entry
//   o_empty, o_full       : occupancy flags
//   o_count               : occupied entries
module prefetch_fifo #(
  parameter int unsigned WIDTH = 27,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_head,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  // Pointer and count bookkeeping; pointers wrap naturally since DEPTH is 2^n.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage needs no reset; the count gates every read.
  always_ff @(posedge i_clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_count = r_count;

endmodule

// File: rtl/instruction_prefetch_buffer.sv
// Instruction fetch stage: prefetches sequential words from instruction memory
// into a small FIFO and hands the word at control's PC to its instruction register.
// A request whose address does not match the FIFO head (or the next fetch address
// when empty) is a branch: the FIFO is flushed and fetching restarts there.
// Optional build macro: PREFETCH_BYPASS_EN enables same-cycle pass-through of
// memory data when the FIFO is empty and the acked address is the one requested.
// Ports:
//   clock_in, reset_in            : clock, async active-low reset
//   fetch_addr_in, fetch_req_in   : control's PC and request (held until transfer)
//   instruction_out/_valid_out    : instruction for fetch_addr_in (combinational)
//   mem_addr_out, mem_req_out     : memory read request (registered)
//   mem_data_in, mem_ack_in       : memory read completion
//   fill_level_out                : occupied FIFO entries
module instruction_prefetch_buffer
  import prefetch_pkg::*;
#(
  parameter int unsigned               OPERAND_WIDTH     = OPERAND_WIDTH_DEF,
  parameter int unsigned               INSTRUCTION_WIDTH = INSTRUCTION_WIDTH_DEF,
  parameter int unsigned               DEPTH             = DEPTH_DEF,
  parameter logic [OPERAND_WIDTH-1:0]  RESET_ADDR        = '0
) (
  input  logic                         clock_in,
  input  logic                         reset_in,
  input  logic [OPERAND_WIDTH-1:0]     fetch_addr_in,
  input  logic                         fetch_req_in,
  output logic [INSTRUCTION_WIDTH-1:0] instruction_out,
  output logic                         instruction_valid_out,
  output logic [OPERAND_WIDTH-1:0]     mem_addr_out,
  output logic                         mem_req_out,
  input  logic [INSTRUCTION_WIDTH-1:0] mem_data_in,
  input  logic                         mem_ack_in,
  output logic [$clog2(DEPTH):0]       fill_level_out
);

  localparam int unsigned ENTRY_W = OPERAND_WIDTH + INSTRUCTION_WIDTH;

  fsm_state_t                   r_state;
  logic                         r_mem_req;
  logic [OPERAND_WIDTH-1:0]     r_mem_addr;
  logic [OPERAND_WIDTH-1:0]     r_next_addr;

  fsm_state_t                   w_state_nxt;
  logic                         w_mem_req_nxt;
  logic [OPERAND_WIDTH-1:0]     w_mem_addr_nxt;
  logic [OPERAND_WIDTH-1:0]     w_next_addr_nxt;
  logic                         w_push;

  logic [ENTRY_W-1:0]           w_head;
  logic [OPERAND_WIDTH-1:0]     w_head_addr;
  logic [INSTRUCTION_WIDTH-1:0] w_head_instr;
  logic                         w_empty;
  logic                         w_full;
  logic [$clog2(DEPTH):0]       w_count;
  logic                         w_hit;
  logic                         w_miss;
  logic                         w_bypass;

  prefetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (clock_in),
    .i_rst_n (reset_in),
    .i_push  (w_push),
    .i_pop   (w_hit),
    .i_flush (w_miss),
    .i_data  ({r_mem_addr, mem_data_in}),
    .o_head  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_count (w_count)
  );

  assign {w_head_addr, w_head_instr} = w_head;

  // Hit pops the head; anything else that is not "empty and waiting for next_addr" is a redirect.
  assign w_hit  = fetch_req_in & ~w_empty & (w_head_addr == fetch_addr_in);
  assign w_miss = fetch_req_in & ~w_hit & (~w_empty | (r_next_addr != fetch_addr_in));

`ifdef PREFETCH_BYPASS_EN
  assign w_bypass = (r_state == S_WAIT) & w_empty & mem_ack_in & fetch_req_in &
                    (r_mem_addr == fetch_addr_in);
`else
  assign w_bypass = 1'b0;
`endif

  assign instruction_valid_out = w_hit | w_bypass;
  assign instruction_out       = w_hit    ? w_head_instr :
                                 w_bypass ? mem_data_in  : '0;
  assign mem_req_out           = r_mem_req;
  assign mem_addr_out          = r_mem_addr;
  assign fill_level_out        = w_count;

  // Next-state and request logic. At most one request is ever outstanding, so
  // issuing only from S_IDLE with a free slot keeps pushes from overflowing.
  always_comb begin
    w_state_nxt     = r_state;
    w_mem_req_nxt   = r_mem_req;
    w_mem_addr_nxt  = r_mem_addr;
    w_next_addr_nxt = r_next_addr;
    w_push          = 1'b0;

    if (w_miss) w_next_addr_nxt = fetch_addr_in;

    case (r_state)
      S_IDLE: begin
        // A redirect flushes this edge, so the slot is free and the target is fetched directly.
        if (w_miss || !w_full) begin
          w_mem_req_nxt  = 1'b1;
          w_mem_addr_nxt = w_miss ? fetch_addr_in : r_next_addr;
          w_state_nxt    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_ack_in) begin
          w_mem_req_nxt = 1'b0;
          w_state_nxt   = S_IDLE;
          // Redirect on the ack edge wins: data dropped, next_addr already retargeted.
          if (!w_miss) begin
            w_push          = ~w_bypass;
            w_next_addr_nxt = r_mem_addr + OPERAND_WIDTH'(1);
          end
        end else if (w_miss) begin
          w_state_nxt = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (mem_ack_in) begin
          w_mem_req_nxt = 1'b0;
          w_state_nxt   = S_IDLE;
        end
      end
      default: begin
        w_mem_req_nxt = 1'b0;
        w_state_nxt   = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      r_state     <= S_IDLE;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_next_addr <= RESET_ADDR;
    end else begin
      r_state     <= w_state_nxt;
      r_mem_req   <= w_mem_req_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_next_addr <= w_next_addr_nxt;
    end
  end

endmodule

// File: tb/tb_instruction_prefetch_buffer.sv
// Self-checking bench for instruction_prefetch_buffer: directed scenarios plus a
// randomized stream checked against a memory-content function and a simple
// control-side program model.
module tb_instruction_prefetch_buffer;

  localparam int unsigned AW = 11;
  localparam int unsigned IW = 16;

  logic          clk;
  logic          rst_n, rst2_n;
  logic [AW-1:0] fa, fa2;
  logic          freq, freq2;
  logic [IW-1:0] mdata, mdata2;
  logic          mack, mack2;
  logic [IW-1:0] instr, instr2;
  logic          ivalid, ivalid2;
  logic [AW-1:0] maddr, maddr2;
  logic          mreq, mreq2;
  logic [2:0]    fill, fill2;

  int checks;
  int errors;

  // Memory-side responder state
  logic          pend;
  logic [AW-1:0] pend_addr;
  int            lat;

  instruction_prefetch_buffer dut (
    .clock_in              (clk),
    .reset_in              (rst_n),
    .fetch_addr_in         (fa),
    .fetch_req_in          (freq),
    .instruction_out       (instr),
    .instruction_valid_out (ivalid),
    .mem_addr_out          (maddr),
    .mem_req_out           (mreq),
    .mem_data_in           (mdata),
    .mem_ack_in            (mack),
    .fill_level_out        (fill)
  );

  instruction_prefetch_buffer #(.RESET_ADDR(11'h7FE)) dut2 (
    .clock_in              (clk),
    .reset_in              (rst2_n),
    .fetch_addr_in         (fa2),
    .fetch_req_in          (freq2),
    .instruction_out       (instr2),
    .instruction_valid_out (ivalid2),
    .mem_addr_out          (maddr2),
    .mem_req_out           (mreq2),
    .mem_data_in           (mdata2),
    .mem_ack_in            (mack2),
    .fill_level_out        (fill2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents: unique word per address.
  function automatic logic [IW-1:0] memf(input logic [AW-1:0] a);
    return {a[4:0], a} ^ 16'hC3A5;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; freq = 1'b0; fa = '0; mack = 1'b0; mdata = '0; pend = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Memory model: acks a request after a random number of cycles with memf data.
  task automatic mem_drive(input int lat_max);
    mack  = 1'b0;
    mdata = IW'($urandom);
    if (mreq === 1'b1) begin
      if (!pend) begin
        pend      = 1'b1;
        pend_addr = maddr;
        lat       = int'($urandom_range(0, lat_max));
      end
      if (lat == 0) begin
        mack  = 1'b1;
        mdata = memf(pend_addr);
        pend  = 1'b0;
      end else begin
        lat--;
      end
    end else begin
      pend = 1'b0;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      freq = 1'($urandom); fa = AW'($urandom); mack = 1'($urandom); mdata = IW'($urandom);
      #1;
      checks++; if (ivalid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", ivalid); end
      checks++; if (instr !== '0) begin errors++; $display("FAIL reset_instr got %h exp 0", instr); end
      checks++; if (mreq !== 1'b0) begin errors++; $display("FAIL reset_mreq got %b exp 0", mreq); end
      checks++; if (maddr !== '0) begin errors++; $display("FAIL reset_maddr got %h exp 0", maddr); end
      checks++; if (fill !== 3'd0) begin errors++; $display("FAIL reset_fill got %0d exp 0", fill); end
      tick();
    end
    freq = 1'b0; mack = 1'b0; pend = 1'b0;
    rst_n = 1'b1;
    #1;
    checks++; if (mreq !== 1'b0) begin errors++; $display("FAIL release_mreq0 got %b exp 0", mreq); end
    tick();
    checks++; if (mreq !== 1'b1 || maddr !== 11'h000) begin
      errors++; $display("FAIL release_req got req=%b addr=%h exp req=1 addr=000", mreq, maddr);
    end
  endtask

  // Continues from test_reset: request for address 0 outstanding.
  task automatic test_first_latency();
    freq = 1'b1; fa = 11'h000; mack = 1'b1; mdata = memf(11'h000);
    #1;
`ifdef PREFETCH_BYPASS_EN
    checks++; if (ivalid !== 1'b1 || instr !== memf(11'h000)) begin
      errors++; $display("FAIL bypass_ack got v=%b i=%h exp v=1 i=%h", ivalid, instr, memf(11'h000));
    end
`else
    checks++; if (ivalid !== 1'b0) begin errors++; $display("FAIL latency_ack_valid got %b exp 0", ivalid); end
`endif
    tick();
    mack = 1'b0; mdata = IW'($urandom);
    #1;
`ifdef PREFETCH_BYPASS_EN
    checks++; if (fill !== 3'd0) begin errors++; $display("FAIL bypass_fill got %0d exp 0", fill); end
`else
    checks++; if (ivalid !== 1'b1 || instr !== memf(11'h000)) begin
      errors++; $display("FAIL latency_valid got v=%b i=%h exp v=1 i=%h", ivalid, instr, memf(11'h000));
    end
    checks++; if (fill !== 3'd1) begin errors++; $display("FAIL latency_fill got %0d exp 1", fill); end
`endif
    tick();
    freq = 1'b0;
  endtask

  task automatic test_stall();
    do_reset();
    freq = 1'b0;
    for (int c = 0; c < 20; c++) begin
      mem_drive(0);
      #1;
      checks++; if (fill > 3'd4) begin errors++; $display("FAIL stall_fill_bound got %0d exp <=4", fill); end
      tick();
    end
    mack = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (fill !== 3'd4) begin errors++; $display("FAIL stall_fill got %0d exp 4", fill); end
      checks++; if (mreq !== 1'b0) begin errors++; $display("FAIL stall_mreq got %b exp 0", mreq); end
      tick();
    end
  endtask

  // Control model: PC advances after each transfer or branches randomly; data must match memory.
  task automatic run_stream(input int ncyc, input int lat_max, input int branch_pct,
                            input logic [AW-1:0] start_pc);
    logic [AW-1:0] pc;
    logic          xfer;
    int            waits;
    int            served;
    pc = start_pc; freq = 1'b1; xfer = 1'b0; waits = 0; served = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (xfer) begin
        pc   = (int'($urandom_range(0, 99)) < branch_pct) ? AW'($urandom) : pc + AW'(1);
        freq = 1'b0;
        xfer = 1'b0;
      end
      if (!freq) freq = ($urandom_range(0, 3) != 0);
      fa = pc;
      if (pend) begin
        checks++; if (mreq !== 1'b1 || maddr !== pend_addr) begin
          errors++; $display("FAIL stream_req_stable got req=%b addr=%h exp req=1 addr=%h", mreq, maddr, pend_addr);
        end
      end
      mem_drive(lat_max);
      #1;
      checks++; if (fill > 3'd4) begin errors++; $display("FAIL stream_fill got %0d exp <=4", fill); end
      if (ivalid === 1'b1) begin
        checks++; if (!freq || instr !== memf(fa)) begin
          errors++; $display("FAIL stream_data addr=%h req=%b got %h exp %h", fa, freq, instr, memf(fa));
        end
        served++; xfer = 1'b1; waits = 0;
      end else begin
        checks++; if (instr !== '0) begin errors++; $display("FAIL stream_idle_instr got %h exp 0", instr); end
        if (freq) waits++;
      end
      if (waits > 60) begin
        checks++; errors++;
        $display("FAIL stream_timeout addr=%h waited %0d cycles exp <=60", fa, waits);
        break;
      end
      tick();
    end
    mack = 1'b0; freq = 1'b0;
    checks++; if (served < ncyc / 12) begin
      errors++; $display("FAIL stream_throughput got %0d exp >=%0d", served, ncyc / 12);
    end
  endtask

  task automatic test_branch_outstanding();
    logic reached;
    do_reset();
    freq = 1'b1; fa = 11'h010;
    tick();
    freq = 1'b0;
    reached = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (mreq === 1'b1 && maddr === 11'h013) begin reached = 1'b1; break; end
      mem_drive(0);
      tick();
    end
    mack = 1'b0; pend = 1'b0;
    checks++; if (!reached) begin errors++; $display("FAIL branch_setup got addr=%h exp 013 pending", maddr); end
    #1;
    checks++; if (fill !== 3'd3) begin errors++; $display("FAIL branch_prefill got %0d exp 3", fill); end
    freq = 1'b1; fa = 11'h200;
    #1;
    checks++; if (ivalid !== 1'b0) begin errors++; $display("FAIL branch_no_hit got %b exp 0", ivalid); end
    tick();
    #1;
    checks++; if (fill !== 3'd0) begin errors++; $display("FAIL branch_flush got %0d exp 0", fill); end
    checks++; if (mreq !== 1'b1 || maddr !== 11'h013) begin
      errors++; $display("FAIL branch_hold got req=%b addr=%h exp req=1 addr=013", mreq, maddr);
    end
    mack = 1'b1; mdata = memf(11'h013);
    #1;
    checks++; if (ivalid !== 1'b0) begin errors++; $display("FAIL branch_discard_valid got %b exp 0", ivalid); end
    tick();
    mack = 1'b0;
    #1;
    checks++; if (fill !== 3'd0 || mreq !== 1'b0) begin
      errors++; $display("FAIL branch_dropped got fill=%0d req=%b exp fill=0 req=0", fill, mreq);
    end
    tick();
    #1;
    checks++; if (mreq !== 1'b1 || maddr !== 11'h200) begin
      errors++; $display("FAIL branch_refetch got req=%b addr=%h exp req=1 addr=200", mreq, maddr);
    end
    mack = 1'b1; mdata = memf(11'h200);
    #1;
`ifdef PREFETCH_BYPASS_EN
    checks++; if (ivalid !== 1'b1 || instr !== memf(11'h200)) begin
      errors++; $display("FAIL branch_bypass got v=%b i=%h exp v=1 i=%h", ivalid, instr, memf(11'h200));
    end
`endif
    tick();
    mack = 1'b0;
    #1;
`ifndef PREFETCH_BYPASS_EN
    checks++; if (ivalid !== 1'b1 || instr !== memf(11'h200)) begin
      errors++; $display("FAIL branch_first got v=%b i=%h exp v=1 i=%h", ivalid, instr, memf(11'h200));
    end
`else
    checks++; if (fill !== 3'd0) begin errors++; $display("FAIL branch_bypass_fill got %0d exp 0", fill); end
`endif
    freq = 1'b0;
  endtask

  task automatic test_wrap();
    logic [AW-1:0] exp_a [3];
    int idx;
    int iss;
    exp_a[0] = 11'h7FE; exp_a[1] = 11'h7FF; exp_a[2] = 11'h000;
    idx = 0; iss = 0;
    rst2_n = 1'b0; freq2 = 1'b0; fa2 = '0; mack2 = 1'b0; mdata2 = '0;
    tick();
    rst2_n = 1'b1;
    for (int c = 0; c < 40 && idx < 3; c++) begin
      freq2 = 1'b1; fa2 = exp_a[idx];
      mack2 = 1'b0; mdata2 = IW'($urandom);
      if (mreq2 === 1'b1) begin
        if (iss < 3) begin
          checks++; if (maddr2 !== exp_a[iss]) begin
            errors++; $display("FAIL wrap_issue%0d got %h exp %h", iss, maddr2, exp_a[iss]);
          end
        end
        iss++;
        mack2 = 1'b1; mdata2 = memf(maddr2);
      end
      #1;
      if (ivalid2 === 1'b1) begin
        checks++; if (instr2 !== memf(exp_a[idx])) begin
          errors++; $display("FAIL wrap_data%0d got %h exp %h", idx, instr2, memf(exp_a[idx]));
        end
        idx++;
      end
      tick();
    end
    freq2 = 1'b0; mack2 = 1'b0;
    checks++; if (idx != 3) begin errors++; $display("FAIL wrap_done got %0d exp 3", idx); end
  endtask

  task automatic test_ack_and_redirect();
    do_reset();
    tick();
    checks++; if (mreq !== 1'b1 || maddr !== 11'h000) begin
      errors++; $display("FAIL simul_pre got req=%b addr=%h exp req=1 addr=000", mreq, maddr);
    end
    mack = 1'b1; mdata = memf(11'h000); freq = 1'b1; fa = 11'h050;
    #1;
    checks++; if (ivalid !== 1'b0) begin errors++; $display("FAIL simul_valid got %b exp 0", ivalid); end
    tick();
    mack = 1'b0;
    #1;
    checks++; if (fill !== 3'd0 || mreq !== 1'b0) begin
      errors++; $display("FAIL simul_drop got fill=%0d req=%b exp fill=0 req=0", fill, mreq);
    end
    tick();
    #1;
    checks++; if (mreq !== 1'b1 || maddr !== 11'h050) begin
      errors++; $display("FAIL simul_next got req=%b addr=%h exp req=1 addr=050", mreq, maddr);
    end
    freq = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    tick();
    mack = 1'b1; mdata = memf(11'h000);
    tick();
    mack = 1'b0;
    tick();
    #1;
    checks++; if (mreq !== 1'b1 || maddr !== 11'h001 || fill !== 3'd1) begin
      errors++; $display("FAIL midrst_pre got req=%b addr=%h fill=%0d exp 1/001/1", mreq, maddr, fill);
    end
    rst_n = 1'b0;
    #1;
    checks++; if (mreq !== 1'b0 || maddr !== '0 || fill !== 3'd0) begin
      errors++; $display("FAIL midrst_async got req=%b addr=%h fill=%0d exp 0/000/0", mreq, maddr, fill);
    end
    tick();
    mack = 1'b1; mdata = 16'hDEAD;
    tick();
    rst_n = 1'b1;
    tick();
    mack = 1'b0;
    #1;
    checks++; if (fill !== 3'd0 || mreq !== 1'b1 || maddr !== 11'h000) begin
      errors++; $display("FAIL midrst_late_ack got fill=%0d req=%b addr=%h exp 0/1/000", fill, mreq, maddr);
    end
    tick();
    #1;
    checks++; if (fill !== 3'd0 || mreq !== 1'b1 || maddr !== 11'h000) begin
      errors++; $display("FAIL midrst_hold got fill=%0d req=%b addr=%h exp 0/1/000", fill, mreq, maddr);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; freq = 1'b0; fa = '0; mack = 1'b0; mdata = '0;
    rst2_n = 1'b0; freq2 = 1'b0; fa2 = '0; mack2 = 1'b0; mdata2 = '0;
    pend = 1'b0; pend_addr = '0; lat = 0;

    test_reset();
    test_first_latency();
    test_stall();
    run_stream(400, 0, 0, 11'h000);
    do_reset();
    run_stream(800, 3, 20, 11'h000);
    do_reset();
    test_branch_outstanding();
    test_wrap();
    test_ack_and_redirect();
    test_reset_mid_wait();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_prefetch_buffer.md
Name: instruction_prefetch_buffer

Overview:
- Fetch stage directly upstream of the control unit.
- Takes the program-counter address and request from control, fetches instruction words from instruction memory over a req/ack handshake, and prefetches sequential words into a small FIFO.
- Returns the instruction for the requested address to control's instruction register.
- Detects branches by address mismatch, flushes, and refetches from the new address.

Parameters:
- OPERAND_WIDTH, 11, address width; equals the control unit's operand and PC width.
- INSTRUCTION_WIDTH, 16, instruction word width.
- DEPTH, 4, prefetch FIFO entries; power of 2, minimum 2.
- RESET_ADDR, 0, first address fetched after reset.

Ports:
- clock_in  input  1  clock, rising edge.
- reset_in  input  1  asynchronous, active-low reset.
- fetch_addr_in  input  OPERAND_WIDTH  address requested by control (its PC).
- fetch_req_in  input  1  control wants the instruction at fetch_addr_in; held high until the transfer.
- instruction_out  output  INSTRUCTION_WIDTH  instruction to control; 0 when not valid.
- instruction_valid_out  output  1  instruction_out corresponds to fetch_addr_in.
- mem_addr_out  output  OPERAND_WIDTH  instruction memory address.
- mem_req_out  output  1  memory read request.
- mem_data_in  input  INSTRUCTION_WIDTH  memory read data; valid with mem_ack_in.
- mem_ack_in  input  1  memory completes the outstanding request.
- fill_level_out  output  $clog2(DEPTH)+1  occupied FIFO entries.

Behaviour:
- Reset (asynchronous, reset_in=0):
  - FIFO empty, fill_level_out=0, next_addr=RESET_ADDR.
  - FSM to S_IDLE, mem_req_out=0, mem_addr_out=0.
  - instruction_out=0, instruction_valid_out=0.
  - Any outstanding memory transaction is abandoned; a later mem_ack_in is ignored because mem_req_out=0.
- FIFO entry = {addr, instr}.
- Hit (combinational): fetch_req_in & non-empty & head.addr==fetch_addr_in.
  - instruction_valid_out=1, instruction_out=head.instr.
  - Transfer happens on that clock edge; head is popped.
- Miss: fetch_req_in & not hit & (non-empty, or next_addr!=fetch_addr_in). This is a redirect:
  - FIFO flushed.
  - next_addr<=fetch_addr_in.
  - Outstanding request marked for discard.
- Empty FIFO with next_addr==fetch_addr_in: wait, no redirect.
- FSM:
  - S_IDLE: if fill + 0 < DEPTH, assert mem_req_out with mem_addr_out=next_addr, go S_WAIT.
  - S_WAIT: mem_req_out and mem_addr_out held stable until mem_ack_in. On ack:
    - push {mem_addr_out, mem_data_in};
    - next_addr<=mem_addr_out+1, wrapping modulo 2^OPERAND_WIDTH;
    - go S_IDLE.
    - Redirect while in S_WAIT (before ack): go S_DISCARD.
  - S_DISCARD: mem_req_out held with the old address. On ack, data dropped, go S_IDLE; the next request uses the redirected next_addr.
- Issue only if count + outstanding < DEPTH, so a push never overflows.
- Full FIFO: no new request.
- Push and pop on the same edge: count unchanged.
- Ack and redirect on the same edge: redirect wins, data dropped, next_addr = fetch_addr_in.
- Ack in S_IDLE: ignored.
- Minimum latency with the feature off: ack edge pushes; instruction_valid_out earliest next cycle.
- Back-to-back: a request may be reissued the cycle after an ack (S_IDLE lasts one cycle).

Optional Feature:
- Macro: PREFETCH_BYPASS_EN.
- Defined: in S_WAIT with FIFO empty, mem_ack_in & fetch_req_in & mem_addr_out==fetch_addr_in gives a same-cycle pass-through:
  - instruction_out=mem_data_in, instruction_valid_out=1;
  - no push; next_addr still advances.
- Undefined: no combinational path from mem_data_in to the instruction outputs; data is always returned via the FIFO.

Decomposition:
- Package prefetch_pkg:
  - fsm enum {S_IDLE, S_WAIT, S_DISCARD};
  - default width constants;
  - packed struct fetch_entry_t {addr, instr}.
- Sub-module prefetch_fifo:
  - DEPTH-entry storage with read/write pointers and count;
  - push, pop, flush (flush overrides push on the same edge);
  - head, empty, full outputs.
- Top level contains the FSM, next_addr, and the hit/miss logic.

Test Plan:
- Reset: hold reset_in=0, toggle inputs -> all outputs 0, fill_level_out=0. Release -> mem_req_out=1 with mem_addr_out=0 one cycle later.
- Sequential stream, ack 1 cycle after req, control requesting 0,1,2,...:
  - instructions returned in order, addresses match;
  - fill_level_out never exceeds 4;
  - with control stalled, mem_req_out drops at 4 entries.
- Branch with request outstanding: FIFO holds 0x010–0x012, req to 0x013 pending, control requests 0x200:
  - flush, S_DISCARD, ack data for 0x013 dropped;
  - next mem_addr_out=0x200; first valid instruction is for 0x200.
- Wrap-around: RESET_ADDR=0x7FE -> fetch addresses 0x7FE, 0x7FF, 0x000; data correct.
- Simultaneous ack and redirect to 0x050 on the same edge -> data dropped, fill=0, next request to 0x050.
- Reset asserted mid-S_WAIT, then late mem_ack_in -> no push, fetch restarts at RESET_ADDR.
- PREFETCH_BYPASS_EN defined: empty FIFO, ack for the requested address -> instruction_valid_out=1 in the ack cycle, fill_level_out stays 0.
